// File: rtl/ifu_fetch_ctrl.sv
// Fetch-stage control: owns the fetch PC and issues one outstanding request at a time.
// The returned instruction is held for decode; redirects from execute discard any in-flight response.
module ifu_fetch_ctrl #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             mem_req_valid,
  output logic [WIDTH-1:0] mem_req_addr,
  input  logic             mem_req_ready,
  input  logic             mem_rsp_valid,
  input  logic [31:0]      mem_rsp_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_pc,
  output logic [31:0]      out_inst,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pc;
  logic             drop;
  logic [WIDTH-1:0] redirect_aligned;

  assign redirect_aligned = {redirect_pc[WIDTH-1:2], 2'b00};

  // A redirect withdraws the request so the old address never reaches memory.
  assign mem_req_valid = (state == REQ) && !rst && !redirect_valid;
  assign mem_req_addr  = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= '0;
    end else begin
      case (state)
        REQ: begin
          if (redirect_valid) begin
            pc <= redirect_aligned;
          end else if (mem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            if (drop || redirect_valid) begin
              drop  <= 1'b0;
              state <= REQ;
              if (redirect_valid) pc <= redirect_aligned;
            end else begin
              out_inst  <= mem_rsp_data;
              out_pc    <= pc;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end else if (redirect_valid) begin
            pc   <= redirect_aligned;
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            out_valid <= 1'b0;
            pc        <= redirect_aligned;
            state     <= REQ;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            pc        <= pc + WIDTH'(4);
            state     <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

  // Memory may only answer while a request is outstanding.
  always_ff @(posedge clk) begin
    if (!rst && mem_rsp_valid) begin
      assert (state == WAIT);
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed vector bench for ifu_fetch_ctrl: each record drives one cycle and checks pre-edge outputs.
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] R = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;

  always #5 clk = ~clk;

  ifu_fetch_ctrl #(.WIDTH(32), .RESET_PC(R)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready)
  );

  typedef struct {
    logic        rst, rv;
    logic [31:0] rpc;
    logic        rq, sv;
    logic [31:0] sd;
    logic        ordy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_opc, e_oi;
  } vec_t;

  vec_t vq[$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic add(input logic r, input logic rv, input logic [31:0] rpc, input logic rq,
                     input logic sv, input logic [31:0] sd, input logic ordy,
                     input logic e_req, input logic [31:0] e_addr, input logic e_ov,
                     input logic [31:0] e_opc, input logic [31:0] e_oi);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rq = rq; v.sv = sv; v.sd = sd; v.ordy = ordy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov; v.e_opc = e_opc; v.e_oi = e_oi;
    vq.push_back(v);
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rq,
                       input logic sv, input logic [31:0] sd, input logic ordy);
    rst = r; redirect_valid = rv; redirect_pc = rpc; mem_req_ready = rq;
    mem_rsp_valid = sv; mem_rsp_data = sd; out_ready = ordy;
  endtask

  task automatic check(input string name, input logic e_req, input logic [31:0] e_addr,
                       input logic e_ov, input logic [31:0] e_opc, input logic [31:0] e_oi);
    applied++;
    if (mem_req_valid !== e_req || mem_req_addr !== e_addr || out_valid !== e_ov ||
        out_pc !== e_opc || out_inst !== e_oi) begin
      miscompares++;
      $display("FAIL %s: got req=%b addr=%h ov=%b pc=%h inst=%h, want req=%b addr=%h ov=%b pc=%h inst=%h",
               name, mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst,
               e_req, e_addr, e_ov, e_opc, e_oi);
    end
  endtask

  initial begin
    int cyc;
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);

    //   rst rv rpc           rq sv sd            ordy | req addr          ov pc            inst
    add(1, 0, 0,            0, 0, 0,            0,  0, R,            0, 0,            0);
    add(0, 0, 0,            1, 0, 0,            1,  1, R,            0, 0,            0);
    add(0, 0, 0,            0, 1, 32'h413,      1,  0, R,            0, 0,            0);
    add(0, 0, 0,            0, 0, 0,            1,  0, R,            1, R,            32'h413);
    add(0, 0, 0,            1, 0, 0,            0,  1, R+4,          0, R,            32'h413);
    add(0, 0, 0,            0, 1, 32'hA00093,   0,  0, R+4,          0, R,            32'h413);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0,          1, 0, 0,            0,  0, R+4,          1, R+4,          32'hA00093);
    add(0, 0, 0,            0, 0, 0,            1,  0, R+4,          1, R+4,          32'hA00093);
    add(0, 0, 0,            1, 0, 0,            0,  1, R+8,          0, R+4,          32'hA00093);
    // redirect while waiting, late response is dropped
    add(0, 1, 32'h80001003, 0, 0, 0,            0,  0, R+8,          0, R+4,          32'hA00093);
    add(0, 0, 0,            0, 0, 0,            0,  0, 32'h80001000, 0, R+4,          32'hA00093);
    add(0, 0, 0,            0, 1, 32'hDEADBEEF, 0,  0, 32'h80001000, 0, R+4,          32'hA00093);
    add(0, 0, 0,            0, 0, 0,            0,  1, 32'h80001000, 0, R+4,          32'hA00093);
    add(0, 0, 0,            1, 0, 0,            0,  1, 32'h80001000, 0, R+4,          32'hA00093);
    add(0, 0, 0,            0, 1, 32'h00100073, 0,  0, 32'h80001000, 0, R+4,          32'hA00093);
    // redirect beats out_ready in HOLD
    add(0, 1, 32'h80000100, 0, 0, 0,            1,  0, 32'h80001000, 1, 32'h80001000, 32'h00100073);
    for (int i = 0; i < 3; i++)
      add(0, 0, 0,          0, 0, 0,            0,  1, 32'h80000100, 0, 32'h80001000, 32'h00100073);
    add(0, 1, 32'h80000200, 0, 0, 0,            0,  0, 32'h80000100, 0, 32'h80001000, 32'h00100073);
    add(0, 0, 0,            0, 0, 0,            0,  1, 32'h80000200, 0, 32'h80001000, 32'h00100073);
    add(0, 0, 0,            1, 0, 0,            0,  1, 32'h80000200, 0, 32'h80001000, 32'h00100073);
    add(0, 0, 0,            0, 1, 32'h11111111, 1,  0, 32'h80000200, 0, 32'h80001000, 32'h00100073);
    add(0, 0, 0,            0, 0, 0,            1,  0, 32'h80000200, 1, 32'h80000200, 32'h11111111);
    // wrap at top of address space, low bits masked
    add(0, 1, 32'hFFFFFFFE, 0, 0, 0,            0,  0, 32'h80000204, 0, 32'h80000200, 32'h11111111);
    add(0, 0, 0,            1, 0, 0,            0,  1, 32'hFFFFFFFC, 0, 32'h80000200, 32'h11111111);
    add(0, 0, 0,            0, 1, 32'h22222222, 0,  0, 32'hFFFFFFFC, 0, 32'h80000200, 32'h11111111);
    add(0, 0, 0,            0, 0, 0,            1,  0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h22222222);
    add(0, 0, 0,            1, 0, 0,            0,  1, 32'h00000000, 0, 32'hFFFFFFFC, 32'h22222222);
    // reset while waiting
    add(1, 0, 0,            0, 0, 0,            0,  0, 32'h00000000, 0, 32'hFFFFFFFC, 32'h22222222);
    add(0, 0, 0,            1, 0, 0,            0,  1, R,            0, 0,            0);
    // redirect coincident with response
    add(0, 1, 32'h80000400, 0, 1, 32'h33333333, 0,  0, R,            0, 0,            0);
    add(0, 0, 0,            1, 0, 0,            0,  1, 32'h80000400, 0, 0,            0);
    // back-to-back redirects in WAIT: last one wins
    add(0, 1, 32'h80000500, 0, 0, 0,            0,  0, 32'h80000400, 0, 0,            0);
    add(0, 1, 32'h80000600, 0, 0, 0,            0,  0, 32'h80000500, 0, 0,            0);
    add(0, 0, 0,            0, 1, 32'h44444444, 0,  0, 32'h80000600, 0, 0,            0);
    add(0, 0, 0,            0, 0, 0,            0,  1, 32'h80000600, 0, 0,            0);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].rv, vq[i].rpc, vq[i].rq, vq[i].sv, vq[i].sd, vq[i].ordy);
      #1;
      check($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_ov, vq[i].e_opc, vq[i].e_oi);
    end

    // Best-case latency: accept in N, respond N+1, out_valid in N+2, next request N+3.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 1);
    #1 check("lat_req", 1, R, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 32'h0000_0013, 1);
    #1 check("lat_wait", 0, R, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1);
    #1 check("lat_out", 0, R, 1, R, 32'h0000_0013);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 check("lat_next", 1, R+4, 0, R, 32'h0000_0013);

    // Stalled memory: request must be held with a stable address, then accepted.
    cyc = 0;
    while (cyc < 4) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0);
      #1 check($sformatf("stall%0d", cyc), 1, R+4, 0, R, 32'h0000_0013);
      cyc++;
    end
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 0);
    #1 check("stall_accept", 1, R+4, 0, R, 32'h0000_0013);
    // Bounded wait for the WAIT state to drop the request.
    cyc = 0;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    while (mem_req_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    applied++;
    if (cyc != 0) begin
      miscompares++;
      $display("FAIL stall_wait: request still valid after %0d cycles, want 0", cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Upstream control for the instruction fetch stage.
- Owns the architectural fetch PC and issues one-outstanding fetch requests over a valid/ready request and valid response interface to instruction memory.
- Buffers each returned instruction and hands it to the decode stage with a valid/ready handshake.
- Handles redirects from execute (branch/jump/trap), discarding any in-flight response.

Parameters:
- WIDTH, 32, PC/address width in bits.
- RESET_PC, 32'h8000_0000, fetch address after reset (WIDTH bits).

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- redirect_valid  input  1  execute requests a PC change this cycle.
- redirect_pc  input  WIDTH  new fetch address; bits [1:0] are ignored and forced to 0.
- mem_req_valid  output  1  fetch request valid.
- mem_req_addr  output  WIDTH  fetch address (= pc).
- mem_req_ready  input  1  memory accepts the request.
- mem_rsp_valid  input  1  response data valid, one cycle per response.
- mem_rsp_data  input  32  fetched instruction word.
- out_valid  output  1  held instruction valid to decode.
- out_pc  output  WIDTH  PC of the held instruction.
- out_inst  output  32  held instruction.
- out_ready  input  1  decode consumes the instruction.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- States: REQ, WAIT, HOLD. One internal drop flag.
- Reset (rst high at posedge):
  - state=REQ, pc=RESET_PC, drop=0, out_valid=0, out_inst=0, out_pc=0.
  - mem_req_valid=0 while rst is high.
- mem_req_valid = (state==REQ) && !rst && !redirect_valid. A redirect suppresses the request that cycle. mem_req_addr = pc at all times.
- REQ:
  - redirect_valid -> pc<=redirect_pc, stay REQ.
  - else mem_req_ready -> WAIT.
  - else hold the request stable (valid and address unchanged until accepted).
- WAIT:
  - mem_rsp_valid && (drop || redirect_valid) -> discard data, drop<=0, go REQ; if redirect_valid, also pc<=redirect_pc.
  - mem_rsp_valid otherwise -> out_inst<=mem_rsp_data, out_pc<=pc, out_valid<=1, go HOLD.
  - redirect_valid without response -> pc<=redirect_pc, drop<=1, stay WAIT. Repeated redirects update pc only; the last one wins.
- HOLD:
  - out_valid=1; out_inst and out_pc are stable.
  - redirect_valid -> out_valid<=0, pc<=redirect_pc, go REQ. Redirect has priority over out_ready, so the held instruction is killed.
  - else out_ready -> out_valid<=0, pc<=pc+4, go REQ.
- Arithmetic: pc+4 is modulo 2^WIDTH; 0xFFFF_FFFC wraps to 0x0000_0000.
- Latency and throughput:
  - Best case is request accepted in cycle N, response in N+1, out_valid in N+2, consumed in N+2, next request in N+3.
  - Throughput is at most one instruction per 3 cycles. Bubbles are acceptable.
- mem_rsp_valid in REQ or HOLD is a protocol violation: ignore it and flag it with a simulation assertion.
- Reset mid-operation, in any state, returns to the reset values the next cycle. A response for a pre-reset request that arrives after reset is ignored in REQ; the memory model must not emit it.
- Outputs are registered except mem_req_valid/mem_req_addr, which derive from state/pc plus the redirect gating.

Test Plan:
- Reset then mem_req_ready=1, rsp one cycle later with 0x00000413, out_ready=1 → mem_req_addr=0x80000000; out_valid=1, out_pc=0x80000000, out_inst=0x00000413; next request addr 0x80000004.
- Decode backpressure: out_ready=0 for 5 cycles in HOLD → out_valid, out_pc, out_inst stable, mem_req_valid=0 throughout; out_ready=1 → next request at pc+4.
- Redirect in WAIT to 0x80001003, rsp 0xDEADBEEF two cycles later → data discarded, out_valid stays 0, next request addr 0x80001000, drop cleared.
- Redirect in HOLD with out_ready=1 simultaneously to 0x80000100 → out_valid drops, no pc+4, next request addr 0x80000100.
- Memory stall with mem_req_ready=0 for 4 cycles → mem_req_valid=1 and addr constant; a redirect during the stall changes the address and gates valid low that cycle.
- Wrap: redirect to 0xFFFFFFFC, complete the fetch → next request addr 0x00000000. Assert rst during WAIT → next cycle state REQ, out_valid=0, addr=RESET_PC.
